// File: rtl/fft_frame_sequencer.sv
// rtl/fft_frame_sequencer.sv - frame sequencer for the MODIFY_FFT2 core: load, start, compute, unload
//
// Ports:
//   clk, rst_n            clock; rst_n is a synchronous ACTIVE-HIGH reset
//   s_valid/s_ready       input sample handshake, s_re/s_im signed samples
//   load_data, fft_re_i, fft_im_i, invert_addr
//                         core write strobe, data and bit-reversed address
//   start_flag            one-cycle core start pulse
//   finish_FFT            core done indication
//   en_out_data           core output enable, held through the unload phase
//   core_en_o, core_re_o, core_im_o
//                         core result stream
//   m_valid, m_re, m_im, m_last
//                         framed output stream (not stallable)
//   busy                  any state other than IDLE
//   frame_done            one-cycle pulse on frame completion
//   err_timeout           one-cycle pulse on watchdog abort
module fft_frame_sequencer #(
  parameter int bit_width = 29,
  parameter int N         = 16,
  parameter int SIZE      = 4,
  parameter int TIMEOUT   = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [bit_width-1:0] s_re,
  input  logic [bit_width-1:0] s_im,
  output logic                 load_data,
  output logic [bit_width-1:0] fft_re_i,
  output logic [bit_width-1:0] fft_im_i,
  output logic [SIZE:0]        invert_addr,
  output logic                 start_flag,
  input  logic                 finish_FFT,
  output logic                 en_out_data,
  input  logic                 core_en_o,
  input  logic [bit_width-1:0] core_re_o,
  input  logic [bit_width-1:0] core_im_o,
  output logic                 m_valid,
  output logic [bit_width-1:0] m_re,
  output logic [bit_width-1:0] m_im,
  output logic                 m_last,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 err_timeout
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_START   = 3'd2,
    S_COMPUTE = 3'd3,
    S_UNLOAD  = 3'd4
  } state_t;

  localparam logic [SIZE-1:0] LAST_BEAT = SIZE'(N - 1);
  localparam logic [15:0]     WD_LIMIT  = 16'(TIMEOUT - 1);

  state_t          state;
  state_t          state_nxt;
  logic [SIZE-1:0] beat_cnt;
  logic [15:0]     wd_cnt;

  logic            accept;
  logic            in_watch;
  logic            wd_expire;
  logic            finish_seen;
  logic            out_beat;
  logic            last_beat_in;

  logic            load_data_d;
  logic [SIZE:0]   invert_addr_d;
  logic            start_flag_d;
  logic            en_out_data_d;
  logic            m_valid_d;
  logic            m_last_d;
  logic            frame_done_d;
  logic            err_timeout_d;

  function automatic logic [SIZE-1:0] bitrev(input logic [SIZE-1:0] v);
    logic [SIZE-1:0] r;
    for (int i = 0; i < SIZE; i++) begin
      r[i] = v[SIZE-1-i];
    end
    return r;
  endfunction

  assign s_ready      = (state == S_IDLE) || (state == S_LOAD);
  assign busy         = (state != S_IDLE);
  assign accept       = s_valid && s_ready;
  assign in_watch     = (state == S_COMPUTE) || (state == S_UNLOAD);
  // The watchdog fires on the last allowed cycle so the abort lands exactly
  // TIMEOUT cycles after COMPUTE was entered.
  assign wd_expire    = in_watch && (wd_cnt == WD_LIMIT);
  // wd_cnt is zero only in the first COMPUTE cycle, which masks finish_FFT
  // there (a level left over from the previous frame must not count).
  assign finish_seen  = (state == S_COMPUTE) && finish_FFT && (wd_cnt != '0);
  assign out_beat     = (state == S_UNLOAD) && core_en_o;
  assign last_beat_in = out_beat && (beat_cnt == LAST_BEAT);

  // State register
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (accept) state_nxt = S_LOAD;
      S_LOAD:    if (accept && (beat_cnt == LAST_BEAT)) state_nxt = S_START;
      S_START:   state_nxt = S_COMPUTE;
      S_COMPUTE: begin
        if (wd_expire) begin
          state_nxt = S_IDLE;
        end else if (finish_seen) begin
          state_nxt = S_UNLOAD;
        end
      end
      // Completion and expiry both return to IDLE; which pulse fires is
      // decided in the output logic.
      S_UNLOAD:  if (last_beat_in || wd_expire) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Next values of the registered outputs
  always_comb begin
    load_data_d   = accept;
    invert_addr_d = {1'b0, bitrev(beat_cnt)};
    start_flag_d  = (state == S_START);
    en_out_data_d = (state_nxt == S_UNLOAD);
    m_valid_d     = out_beat;
    m_last_d      = last_beat_in;
    frame_done_d  = last_beat_in;
    err_timeout_d = wd_expire && !last_beat_in;
  end

  // Beat counter is shared by load and unload; it wraps naturally at N and
  // is forced back to 0 when a frame is abandoned mid-unload.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      beat_cnt <= '0;
      wd_cnt   <= '0;
    end else begin
      if (wd_expire && !last_beat_in) begin
        beat_cnt <= '0;
      end else if (accept || out_beat) begin
        beat_cnt <= beat_cnt + SIZE'(1);
      end
      if (in_watch) begin
        wd_cnt <= wd_cnt + 16'd1;
      end else begin
        wd_cnt <= '0;
      end
    end
  end

  // Registered outputs; data registers only move with their strobes
  always_ff @(posedge clk) begin
    if (rst_n) begin
      load_data   <= 1'b0;
      fft_re_i    <= '0;
      fft_im_i    <= '0;
      invert_addr <= '0;
      start_flag  <= 1'b0;
      en_out_data <= 1'b0;
      m_valid     <= 1'b0;
      m_re        <= '0;
      m_im        <= '0;
      m_last      <= 1'b0;
      frame_done  <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      load_data   <= load_data_d;
      start_flag  <= start_flag_d;
      en_out_data <= en_out_data_d;
      m_valid     <= m_valid_d;
      m_last      <= m_last_d;
      frame_done  <= frame_done_d;
      err_timeout <= err_timeout_d;
      if (accept) begin
        fft_re_i    <= s_re;
        fft_im_i    <= s_im;
        invert_addr <= invert_addr_d;
      end
      if (m_valid_d) begin
        m_re <= core_re_o;
        m_im <= core_im_o;
      end
    end
  end

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// tb/tb_fft_frame_sequencer.sv - self-checking bench for fft_frame_sequencer
module tb_fft_frame_sequencer;

  localparam int BW   = 29;
  localparam int N    = 16;
  localparam int SIZE = 4;
  localparam int TMO  = 50;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          s_valid;
  logic          s_ready;
  logic [BW-1:0] s_re;
  logic [BW-1:0] s_im;
  logic          load_data;
  logic [BW-1:0] fft_re_i;
  logic [BW-1:0] fft_im_i;
  logic [SIZE:0] invert_addr;
  logic          start_flag;
  logic          finish_FFT;
  logic          en_out_data;
  logic          core_en_o;
  logic [BW-1:0] core_re_o;
  logic [BW-1:0] core_im_o;
  logic          m_valid;
  logic [BW-1:0] m_re;
  logic [BW-1:0] m_im;
  logic          m_last;
  logic          busy;
  logic          frame_done;
  logic          err_timeout;

  always #5 clk = ~clk;

  fft_frame_sequencer #(
    .bit_width(BW),
    .N(N),
    .SIZE(SIZE),
    .TIMEOUT(TMO)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .s_re(s_re),
    .s_im(s_im),
    .load_data(load_data),
    .fft_re_i(fft_re_i),
    .fft_im_i(fft_im_i),
    .invert_addr(invert_addr),
    .start_flag(start_flag),
    .finish_FFT(finish_FFT),
    .en_out_data(en_out_data),
    .core_en_o(core_en_o),
    .core_re_o(core_re_o),
    .core_im_o(core_im_o),
    .m_valid(m_valid),
    .m_re(m_re),
    .m_im(m_im),
    .m_last(m_last),
    .busy(busy),
    .frame_done(frame_done),
    .err_timeout(err_timeout)
  );

  // One record per load beat: stimulus sample and the core address it must land on
  typedef struct {
    logic [BW-1:0] re;
    logic [BW-1:0] im;
    logic [SIZE:0] addr;
  } ld_vec_t;

  ld_vec_t tab[N];
  int      rev_order[N] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

  int checks     = 0;
  int errors     = 0;
  int exp_done   = 0;
  int exp_tmo    = 0;
  int seen_done  = 0;
  int seen_tmo   = 0;

  always @(negedge clk) begin
    if (frame_done)  seen_done++;
    if (err_timeout) seen_tmo++;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_s_ready"},     s_ready, 1);
    chk({tag, "_busy"},        busy, 0);
    chk({tag, "_load_data"},   load_data, 0);
    chk({tag, "_fft_re_i"},    fft_re_i, 0);
    chk({tag, "_invert_addr"}, invert_addr, 0);
    chk({tag, "_start_flag"},  start_flag, 0);
    chk({tag, "_en_out_data"}, en_out_data, 0);
    chk({tag, "_m_valid"},     m_valid, 0);
    chk({tag, "_m_re"},        m_re, 0);
    chk({tag, "_m_last"},      m_last, 0);
    chk({tag, "_frame_done"},  frame_done, 0);
    chk({tag, "_err_timeout"}, err_timeout, 0);
  endtask

  // gap_mode: 0 contiguous, 1 alternate cycles, 2 random.
  // fin_at: compute cycle (0 = first COMPUTE cycle) in which finish_FFT is
  // raised, -1 for never. out_gap: percent chance a core beat is skipped.
  // rst_after: assert reset once this many core beats were issued (0 = no).
  task automatic run_frame(input int gap_mode, input int fin_at, input int out_gap,
                           input int rst_after, input bit fin_first);
    int   k        = 0;
    int   cyc      = 0;
    int   prev_k   = 0;
    bit   prev_acc = 0;
    bit   v;
    int   beats    = 0;
    bit   prev_bv  = 0;
    bit   prev_last = 0;
    bit   beat;
    bit   end_cycle;
    bit   rst_cycle;
    bit   in_unl;
    logic [BW-1:0] prev_re = '0;
    logic [BW-1:0] prev_im = '0;

    // Load phase: s_ready is expected high throughout
    while (k < N) begin
      @(posedge clk); #1;
      if (gap_mode == 0)      v = 1'b1;
      else if (gap_mode == 1) v = (cyc % 2) == 0;
      else                    v = (cyc > 60) ? 1'b1 : 1'($urandom_range(0, 1));
      s_valid    = v;
      s_re       = v ? tab[k].re : BW'($urandom);
      s_im       = v ? tab[k].im : BW'($urandom);
      finish_FFT = 1'($urandom_range(0, 1));
      core_en_o  = 1'($urandom_range(0, 1));
      core_re_o  = BW'($urandom);
      core_im_o  = BW'($urandom);
      @(negedge clk);
      chk("load_s_ready", s_ready, 1);
      chk("load_busy", busy, k != 0);
      chk("load_data", load_data, prev_acc);
      if (prev_acc) begin
        chk("load_addr", invert_addr, tab[prev_k].addr);
        chk("load_re", fft_re_i, tab[prev_k].re);
        chk("load_im", fft_im_i, tab[prev_k].im);
      end
      chk("load_start_flag", start_flag, 0);
      chk("load_en_out", en_out_data, 0);
      chk("load_m_valid", m_valid, 0);
      chk("load_err", err_timeout, 0);
      prev_acc = v;
      prev_k   = k;
      if (v) k++;
      cyc++;
    end

    // START cycle: last beat written, offered beats refused
    @(posedge clk); #1;
    s_valid    = 1'b1;
    s_re       = BW'($urandom);
    finish_FFT = 1'($urandom_range(0, 1));
    core_en_o  = 1'($urandom_range(0, 1));
    @(negedge clk);
    chk("start_s_ready", s_ready, 0);
    chk("start_busy", busy, 1);
    chk("start_load_data", load_data, 1);
    chk("start_load_addr", invert_addr, tab[N-1].addr);
    chk("start_load_re", fft_re_i, tab[N-1].re);
    chk("start_start_flag", start_flag, 0);

    // Compute and unload, rel counts cycles since COMPUTE was entered
    for (int rel = 0; rel <= TMO; rel++) begin
      end_cycle = prev_last || (rel == TMO);
      rst_cycle = (rst_after > 0) && (beats == rst_after) && !end_cycle;
      in_unl    = !end_cycle && (fin_at >= 0) && (rel > fin_at);
      beat      = in_unl && !rst_cycle && ($urandom_range(1, 100) > out_gap);
      @(posedge clk); #1;
      rst_n      = rst_cycle;
      s_valid    = (end_cycle || rst_cycle) ? 1'b0 : 1'($urandom_range(0, 1));
      finish_FFT = (rel == fin_at) || (rel == 0 && fin_first);
      core_en_o  = in_unl ? beat : (rst_cycle ? 1'b0 : 1'($urandom_range(0, 1)));
      core_re_o  = BW'($urandom);
      core_im_o  = BW'($urandom);
      @(negedge clk);
      chk("run_start_flag", start_flag, rel == 0);
      chk("run_load_data", load_data, 0);
      chk("run_en_out", en_out_data, in_unl);
      chk("run_m_valid", m_valid, prev_bv);
      if (prev_bv) begin
        chk("run_m_re", m_re, prev_re);
        chk("run_m_im", m_im, prev_im);
      end
      chk("run_m_last", m_last, prev_last);
      chk("run_frame_done", frame_done, prev_last);
      chk("run_err_timeout", err_timeout, (rel == TMO) && !prev_last);
      chk("run_busy", busy, !end_cycle);
      chk("run_s_ready", s_ready, end_cycle);
      if (end_cycle) begin
        if (prev_last) exp_done++;
        else           exp_tmo++;
        return;
      end
      if (rst_cycle) begin
        @(posedge clk); #1;
        rst_n      = 1'b0;
        s_valid    = 1'b0;
        finish_FFT = 1'b0;
        core_en_o  = 1'b0;
        @(negedge clk);
        chk_idle_zero("rst_mid");
        return;
      end
      prev_bv   = beat;
      prev_last = beat && (beats == N - 1);
      prev_re   = core_re_o;
      prev_im   = core_im_o;
      if (beat) beats++;
    end
  endtask

  task automatic randomize_tab();
    for (int i = 0; i < N; i++) begin
      tab[i].re = BW'($urandom);
      tab[i].im = BW'($urandom);
    end
  endtask

  initial begin
    rst_n      = 1'b1;
    s_valid    = 1'b0;
    s_re       = '0;
    s_im       = '0;
    finish_FFT = 1'b0;
    core_en_o  = 1'b0;
    core_re_o  = '0;
    core_im_o  = '0;

    for (int i = 0; i < N; i++) begin
      tab[i].re   = BW'(i);
      tab[i].im   = BW'(-i);
      tab[i].addr = (SIZE + 1)'(rev_order[i]);
    end

    @(posedge clk); #1;
    @(negedge clk);
    chk_idle_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk_idle_zero("post_reset");

    // Contiguous frame with s_re=k, s_im=-k
    run_frame(0, 3, 0, 0, 0);

    // Alternate-cycle input, finish also raised in the masked first cycle
    randomize_tab();
    run_frame(1, 5, 0, 0, 1);

    // No finish_FFT: watchdog abort
    randomize_tab();
    run_frame(2, -1, 0, 0, 0);

    // Reset after the 7th output beat, then a normal frame
    randomize_tab();
    run_frame(0, 2, 0, 7, 0);
    randomize_tab();
    run_frame(0, 1, 0, 0, 0);

    // Back-to-back: offered in the cycle right after frame_done
    randomize_tab();
    run_frame(0, 1, 0, 0, 0);
    randomize_tab();
    run_frame(0, 2, 0, 0, 0);

    // Randomized frames; long gaps sometimes trip the watchdog mid-unload
    for (int f = 0; f < 8; f++) begin
      randomize_tab();
      run_frame(2, int'($urandom_range(1, 20)), int'($urandom_range(0, 50)), 0, 1'($urandom_range(0, 1)));
    end

    @(posedge clk); #1;
    s_valid = 1'b0;
    @(negedge clk);
    chk("total_frame_done", seen_done, exp_done);
    chk("total_err_timeout", seen_tmo, exp_tmo);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
